// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, thresholds and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty_bar,
  output logic                  full_bar,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH-1:0]  count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned          IdxWidth = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] DepthLvl = PTR_WIDTH'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] AfLvl    = PTR_WIDTH'(AF_THRESH);
  localparam logic [PTR_WIDTH-1:0] AeLvl    = PTR_WIDTH'(AE_THRESH);
  localparam logic [PTR_WIDTH-1:0] PtrOne   = PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 rd_ok, wr_ok;
  logic [IdxWidth-1:0]  wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[IdxWidth-1:0];
  assign rd_idx = rd_ptr_q[IdxWidth-1:0];

  // A full FIFO still accepts a write when a read frees the head in the same cycle.
  always_comb begin
    rd_ok = re & (count_q != '0);
    wr_ok = we & ((count_q != DepthLvl) | rd_ok);
  end

  always_comb begin
    wr_ptr_d    = wr_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d    = rd_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d     = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + PtrOne;
      2'b01:   count_d = count_q - PtrOne;
      default: count_d = count_q;
    endcase
    // A fresh error in the clearing cycle must not be lost.
    overflow_d  = (overflow_q & ~err_clr) | (we & ~wr_ok);
    underflow_d = (underflow_q & ~err_clr) | (re & ~rd_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= data_in;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  assign data_out = (count_q != '0) ? mem[rd_idx] : '0;
`else
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
    end else if (rd_ok) begin
      data_out_q <= mem[rd_idx];
    end
  end

  assign data_out = data_out_q;
`endif

  always_comb begin
    count        = count_q;
    empty_bar    = (count_q != '0);
    full_bar     = (count_q != DepthLvl);
    almost_full  = (count_q >= AfLvl);
    almost_empty = (count_q <= AeLvl);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised bench for fifo_sync_param against a queue-based model, plus directed literal checks.
module tb_fifo_sync_param;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          empty_bar, full_bar, almost_full, almost_empty, overflow, underflow;
  logic [PW-1:0] count;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  fifo_sync_param dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .we           (we),
    .data_in      (data_in),
    .re           (re),
    .data_out     (data_out),
    .empty_bar    (empty_bar),
    .full_bar     (full_bar),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of stored words plus the sticky flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  bit m_ovf = 1'b0, m_udf = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    bit m_rd, m_wr;
    if (!reset_n) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_rd = re && (mq.size() != 0);
      m_wr = we && ((mq.size() != DEPTH) || m_rd);
      if (m_rd) m_dout = mq.pop_front();
      if (m_wr) mq.push_back(data_in);
      m_ovf = (m_ovf && !err_clr) || (we && !m_wr);
      m_udf = (m_udf && !err_clr) || (re && !m_rd);
    end
  end

  function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_SYNC_FWFT_EN
    return (mq.size() != 0) ? mq[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      int sz;
      sz = mq.size();
      chk("count", DW'(count), DW'(sz));
      chk("empty_bar", DW'(empty_bar), DW'(sz != 0));
      chk("full_bar", DW'(full_bar), DW'(sz != DEPTH));
      chk("almost_full", DW'(almost_full), DW'(sz >= DEPTH - 2));
      chk("almost_empty", DW'(almost_empty), DW'(sz <= 2));
      chk("overflow", DW'(overflow), DW'(m_ovf));
      chk("underflow", DW'(underflow), DW'(m_udf));
      chk("data_out", data_out, exp_dout());
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
    we = w; re = r; data_in = d; err_clr = c;
    @(negedge clk);
    we = 1'b0; re = 1'b0; err_clr = 1'b0;
  endtask

  task automatic read_word(output logic [DW-1:0] v);
`ifdef FIFO_SYNC_FWFT_EN
    v = data_out;
    cycle(1'b0, 1'b1, '0, 1'b0);
`else
    cycle(1'b0, 1'b1, '0, 1'b0);
    v = data_out;
`endif
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, DW'(count), 0);
    chk({tag, "_empty_bar"}, DW'(empty_bar), 0);
    chk({tag, "_full_bar"}, DW'(full_bar), 1);
    chk({tag, "_almost_empty"}, DW'(almost_empty), 1);
    chk({tag, "_almost_full"}, DW'(almost_full), 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_errors"}, DW'({overflow, underflow}), 0);
  endtask

  // Reset asserted asynchronously in the middle of an active read/write cycle.
  task automatic mid_traffic_reset();
    we = 1'b1; re = 1'b1; data_in = $urandom;
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    reset_n = 1'b1; we = 1'b0; re = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v;

    #1 reset_n = 1'b0;
    #1 check_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst_held");
    reset_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
    chk("fill_count", DW'(count), 16);
    chk("fill_full_bar", DW'(full_bar), 0);
    chk("fill_af", DW'(almost_full), 1);
    cycle(1'b1, 1'b0, 32'hEE, 1'b0);
    chk("ovf_set", DW'(overflow), 1);
    chk("ovf_count", DW'(count), 16);

    for (int i = 0; i < DEPTH; i++) begin
      read_word(v);
      chk($sformatf("drain_%0d", i), v, DW'(i));
    end
    chk("drain_empty", DW'(empty_bar), 0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    chk("udf_set", DW'(underflow), 1);
    chk("udf_count", DW'(count), 0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("err_clr", DW'({overflow, underflow}), 0);

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
    cycle(1'b1, 1'b1, 32'hAA, 1'b0);
    chk("fullrw_count", DW'(count), 16);
    chk("fullrw_ovf", DW'(overflow), 0);
`ifdef FIFO_SYNC_FWFT_EN
    chk("fullrw_head", data_out, 1);
`else
    chk("fullrw_head", data_out, 0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      read_word(v);
      if (i == 0) chk("fullrw_first", v, 1);
      if (i == DEPTH - 1) chk("fullrw_last", v, 32'hAA);
    end

    for (int i = 1; i <= 14; i++) begin
      cycle(1'b1, 1'b0, $urandom, 1'b0);
      if (i == 2) chk("ae_at2", DW'(almost_empty), 1);
      if (i == 3) chk("ae_at3", DW'(almost_empty), 0);
      if (i == 13) chk("af_at13", DW'(almost_full), 0);
      if (i == 14) chk("af_at14", DW'(almost_full), 1);
    end
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, '0, 1'b0);

    // Error set and clear in the same cycle: set wins.
    cycle(1'b0, 1'b1, '0, 1'b1);
    chk("clr_vs_set", DW'(underflow), 1);
    cycle(1'b0, 1'b0, '0, 1'b1);

`ifdef FIFO_SYNC_FWFT_EN
    cycle(1'b1, 1'b0, 32'h55, 1'b0);
    chk("fwft_data", data_out, 32'h55);
    chk("fwft_nonempty", DW'(empty_bar), 1);
    cycle(1'b0, 1'b1, '0, 1'b0);
    chk("fwft_popped", DW'(empty_bar), 0);
    chk("fwft_zero", data_out, 0);
`endif

    mid_traffic_reset();

    for (int blk = 0; blk < 6; blk++) begin
      int pw, pr;
      pw = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 30 : 55;
      pr = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 80 : 55;
      for (int i = 0; i < 400; i++) begin
        cycle($urandom_range(99) < pw, $urandom_range(99) < pr, $urandom,
              $urandom_range(99) < 5);
      end
      if (blk == 2 || blk == 4) mid_traffic_reset();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
